// File: rtl/pcm_to_i2s_pkg.sv
// Shared I2S constants and small decode helpers used by the transmit path.
package pcm_to_i2s_pkg;

   // Sample width per channel; the receiver shares this value.
   localparam int I2S_NUMBER_OF_BITS = 8;
   // sck periods per channel slot; always at least I2S_NUMBER_OF_BITS.
   localparam int I2S_SLOT_BITS      = 16;
   // clk cycles per sck half-period; always at least 1.
   localparam int I2S_CLK_DIV        = 1;

   // What the serial data line carries in a given frame bit position.
   typedef enum logic [1:0] {
      SEG_FRAME_START,   // f == 0: load the new pair, drive left MSB
      SEG_LEFT,          // remaining left sample bits
      SEG_RIGHT,         // right sample bits
      SEG_PAD            // slot padding, driven low
   } bit_seg_e;

   // Bits needed to count 0..n-1, never less than one.
   function automatic int count_width(input int n);
      int w;
      w = (n <= 2) ? 1 : $clog2(n);
      return w;
   endfunction

   // Classify frame index f for a given sample width and slot length.
   function automatic bit_seg_e segment_of(input int f, input int nbits, input int slot);
      bit_seg_e seg;
      seg = SEG_PAD;
      if (f == 0)
         seg = SEG_FRAME_START;
      else if (f < nbits)
         seg = SEG_LEFT;
      else if ((f >= slot) && (f < slot + nbits))
         seg = SEG_RIGHT;
      return seg;
   endfunction

   // ws rises one bit before the right slot and falls one bit before the left slot.
   function automatic logic ws_of(input int f, input int slot);
      logic ws;
      ws = (f >= slot - 1) && (f <= 2*slot - 2);
      return ws;
   endfunction

endpackage

// File: rtl/pcm_to_i2s_clock_gen.sv
// I2S master bit-clock generator: divider, registered sck, fall-tick strobe
// and frame bit index. Kept free of any data path so a master receiver can reuse it.
module i2s_clock_gen
   import pcm_to_i2s_pkg::*;
#(
   parameter int CLK_DIV   = I2S_CLK_DIV,
   parameter int SLOT_BITS = I2S_SLOT_BITS
) (
   input  logic                                    clk,
   input  logic                                    reset,
   output logic                                    o_sck,
   output logic                                    o_fall_tick,
   output logic [count_width(2*SLOT_BITS)-1:0]     o_f_next
);

   localparam int DW = count_width(CLK_DIV);
   localparam int FW = count_width(2*SLOT_BITS);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [FW-1:0] F_LAST   = FW'(2*SLOT_BITS - 1);

   logic [DW-1:0] r_div;
   logic          r_sck;
   logic [FW-1:0] r_f;

   logic          w_wrap;
   logic          w_fall;
   logic [FW-1:0] w_f_next;

   // Divider wrap, sck fall strobe and the frame index the next fall enters.
   // NOTE: every output of a combinational block is assigned on every pass, so no latch can be inferred.
   always_comb begin
      w_wrap   = (r_div == DIV_LAST);
      w_fall   = w_wrap && r_sck;
      w_f_next = (r_f == F_LAST) ? '0 : r_f + 1'b1;
   end

   // Divider, sck and frame index; f resets to its last value so the first fall enters f=0.
   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_div <= '0;
         r_sck <= 1'b0;
         r_f   <= F_LAST;
      end else begin
         r_div <= w_wrap ? '0 : r_div + 1'b1;
         if (w_wrap)
            r_sck <= ~r_sck;
         if (w_fall)
            r_f <= w_f_next;
      end
   end

   assign o_sck       = r_sck;
   assign o_fall_tick = w_fall;
   assign o_f_next    = w_f_next;

endmodule

// File: rtl/pcm_to_i2s.sv
// I2S master transmitter: one-pair holding register behind a valid/ready
// handshake, left/right shift registers and ws/sd decode on sck falls.
module pcm_to_i2s
   import pcm_to_i2s_pkg::*;
#(
   parameter int NUMBER_OF_BITS = I2S_NUMBER_OF_BITS,
   parameter int SLOT_BITS      = I2S_SLOT_BITS,
   parameter int CLK_DIV        = I2S_CLK_DIV
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUMBER_OF_BITS-1:0] in_left,
   input  logic [NUMBER_OF_BITS-1:0] in_right,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic                      sck,
   output logic                      ws,
   output logic                      sd,
   output logic                      frame_start,
   output logic                      underrun
);

   localparam int NB = NUMBER_OF_BITS;
   localparam int FW = count_width(2*SLOT_BITS);

   logic          w_sck;
   logic          w_fall_tick;
   logic [FW-1:0] w_f_next;

   logic          w_accept;
   logic          w_frame_start;
   logic          w_ws_next;
   bit_seg_e      w_seg;
   logic [NB-1:0] w_load_left;
   logic [NB-1:0] w_load_right;

   logic          r_full;
   logic          r_in_ready;
   logic [NB-1:0] r_hold_left;
   logic [NB-1:0] r_hold_right;
   logic [NB-1:0] r_sh_left;
   logic [NB-1:0] r_sh_right;
   logic          r_ws;
   logic          r_sd;

   i2s_clock_gen #(
      .CLK_DIV   (CLK_DIV),
      .SLOT_BITS (SLOT_BITS)
   ) u_clock_gen (
      .clk         (clk),
      .reset       (reset),
      .o_sck       (w_sck),
      .o_fall_tick (w_fall_tick),
      .o_f_next    (w_f_next)
   );

   // Handshake, frame-start detect, bit-position decode and the pair to load (zeros on underrun).
   always_comb begin
      w_accept      = in_valid && r_in_ready;
      w_frame_start = w_fall_tick && (w_f_next == '0);
      w_seg         = segment_of(int'(w_f_next), NB, SLOT_BITS);
      w_ws_next     = ws_of(int'(w_f_next), SLOT_BITS);
      w_load_left   = r_full ? r_hold_left  : '0;
      w_load_right  = r_full ? r_hold_right : '0;
   end

   // Holding register: full flag and registered ready; an accept and a transfer never coincide.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_full     <= 1'b0;
         r_in_ready <= 1'b1;
      end else if (w_accept) begin
         r_full     <= 1'b1;
         r_in_ready <= 1'b0;
      end else if (w_frame_start && r_full) begin
         r_full     <= 1'b0;
         r_in_ready <= 1'b1;
      end
   end

   // Holding data is only ever read while full is set, so it needs no reset.
   // NOTE: pure data storage is left unreset; its qualifying flag carries the reset instead.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_hold_left  <= in_left;
         r_hold_right <= in_right;
      end
   end

   // Serialiser: on each sck fall drive ws and the next sd bit, MSB first.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sh_left  <= '0;
         r_sh_right <= '0;
         r_ws       <= 1'b0;
         r_sd       <= 1'b0;
      end else if (w_fall_tick) begin
         r_ws <= w_ws_next;
         unique case (w_seg)
            SEG_FRAME_START: begin
               r_sd       <= w_load_left[NB-1];
               r_sh_left  <= w_load_left << 1;
               r_sh_right <= w_load_right;
            end
            SEG_LEFT: begin
               r_sd      <= r_sh_left[NB-1];
               r_sh_left <= r_sh_left << 1;
            end
            SEG_RIGHT: begin
               r_sd       <= r_sh_right[NB-1];
               r_sh_right <= r_sh_right << 1;
            end
            default: begin
               r_sd <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready    = r_in_ready;
   assign sck         = w_sck;
   assign ws          = r_ws;
   assign sd          = r_sd;
   assign frame_start = w_frame_start;
   assign underrun    = w_frame_start && !r_full;

endmodule

// File: tb/tb_pcm_to_i2s.sv
// Self-checking bench for pcm_to_i2s: cycle-level timing model of sck/ws/
// frame_start/underrun/in_ready plus a loopback I2S receiver that pops the
// expected-frame scoreboard each time it decodes a complete stereo frame.
module tb_pcm_to_i2s;

   localparam int NB    = 8;
   localparam int SB    = 10;
   localparam int CD    = 3;
   localparam int FRAME = 2*SB*2*CD;

   logic          clk = 1'b0;
   logic          reset;
   logic [NB-1:0] in_left;
   logic [NB-1:0] in_right;
   logic          in_valid;
   logic          in_ready;
   logic          sck;
   logic          ws;
   logic          sd;
   logic          frame_start;
   logic          underrun;

   always #5 clk = ~clk;

   pcm_to_i2s #(
      .NUMBER_OF_BITS (NB),
      .SLOT_BITS      (SB),
      .CLK_DIV        (CD)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .in_left     (in_left),
      .in_right    (in_right),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .sck         (sck),
      .ws          (ws),
      .sd          (sd),
      .frame_start (frame_start),
      .underrun    (underrun)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model state ----------------
   int              n;          // clk cycles since the last reset edge
   int              cur_f;      // frame index currently on the wire
   bit              m_full;     // a pair is held
   logic [NB-1:0]   m_l;
   logic [NB-1:0]   m_r;
   logic            exp_ws;
   bit              cyc_fall;
   logic [2*NB-1:0] q_exp[$];   // expected frames, oldest first

   bit   prev_rst = 1'b1;
   logic prev_sck;
   logic prev_sd;
   bit   prev_fall;

   // loopback receiver state
   logic          rx_ws;
   int            rx_cnt;
   logic [NB-1:0] rx_word;
   logic [NB-1:0] rx_left;
   bit            rx_got_left;
   int            frames_rx = 0;

   task automatic model_reset();
      n           = 0;
      cur_f       = 2*SB - 1;
      m_full      = 1'b0;
      m_l         = '0;
      m_r         = '0;
      exp_ws      = 1'b0;
      q_exp.delete();
      prev_sck    = 1'b0;
      prev_sd     = 1'b0;
      prev_fall   = 1'b0;
      rx_ws       = 1'b1;
      rx_cnt      = NB;
      rx_word     = '0;
      rx_left     = '0;
      rx_got_left = 1'b0;
   endtask

   // Standard I2S receive on each sck rise: a ws change marks the slot
   // boundary, and the following NB rises carry the word MSB first.
   task automatic rx_rise();
      if (ws !== rx_ws) begin
         if (rx_ws == 1'b0) begin
            rx_left     = rx_word;
            rx_got_left = 1'b1;
         end else if (rx_got_left) begin
            frames_rx++;
            if (q_exp.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL frame: decoded %h with no frame expected at %0t", {rx_left, rx_word}, $time);
            end else begin
               check("frame", {rx_left, rx_word}, q_exp.pop_front());
            end
         end
         rx_ws   = ws;
         rx_cnt  = 0;
         rx_word = '0;
      end else if (rx_cnt < NB) begin
         rx_word = {rx_word[NB-2:0], sd};
         rx_cnt++;
      end else begin
         check("pad_bit", sd, 1'b0);
      end
   endtask

   task automatic check_cycle();
      int fnext;
      cyc_fall = (n % (2*CD)) == (2*CD - 1);
      fnext    = (cur_f + 1) % (2*SB);
      check("sck", sck, ((n / CD) % 2) == 1);
      check("frame_start", frame_start, cyc_fall && (fnext == 0));
      check("underrun", underrun, cyc_fall && (fnext == 0) && !m_full);
      check("in_ready", in_ready, !m_full);
      check("ws", ws, exp_ws);
      if (sd !== prev_sd)
         check("sd_changes_only_after_fall", prev_fall, 1'b1);
      if (sck === 1'b1 && prev_sck === 1'b0)
         rx_rise();
      prev_sck  = sck;
      prev_sd   = sd;
      prev_fall = cyc_fall;
   endtask

   // Effect of the clock edge that ends the current cycle.
   task automatic advance();
      bit acc;
      acc = in_valid && !m_full;
      if (cyc_fall) begin
         cur_f = (cur_f + 1) % (2*SB);
         if (cur_f == 0) begin
            q_exp.push_back(m_full ? {m_l, m_r} : '0);
            m_full = 1'b0;
         end
         exp_ws = (cur_f >= SB - 1) && (cur_f <= 2*SB - 2);
      end
      if (acc) begin
         m_full = 1'b1;
         m_l    = in_left;
         m_r    = in_right;
      end
      n++;
   endtask

   // Monitor: sample mid-cycle, compare, then step the model.
   initial begin
      forever begin
         @(negedge clk);
         if (prev_rst)
            model_reset();
         check_cycle();
         if (!reset)
            advance();
         prev_rst = reset;
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle(input int cycles);
      in_valid = 1'b0;
      repeat (cycles) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic send(input logic [NB-1:0] l, input logic [NB-1:0] r);
      int waited;
      waited   = 0;
      in_valid = 1'b1;
      in_left  = l;
      in_right = r;
      @(negedge clk);
      while (in_ready !== 1'b1 && waited < 4*FRAME) begin
         @(negedge clk);
         waited++;
      end
      if (in_ready !== 1'b1) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: in_ready stayed %b for %0d cycles", in_ready, waited);
      end
      @(posedge clk);
      #2;
      in_valid = 1'b0;
   endtask

   initial begin
      logic [NB-1:0] l;
      logic [NB-1:0] r;
      reset    = 1'b1;
      in_valid = 1'b0;
      in_left  = '0;
      in_right = '0;
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b0;

      // Idle after reset: underrun frames of zeros.
      idle(FRAME + 20);

      // Single samples, including the loopback pattern.
      send(8'hA5, 8'h3C);
      idle(2*FRAME);
      send(8'h81, 8'h81);
      idle(2*FRAME);

      // Back-to-back with in_valid held high.
      for (int i = 0; i < 5; i++) begin
         l = NB'(8'h10 + i);
         r = NB'(8'hE0 + i);
         send(l, r);
      end
      idle(2*FRAME);

      // Random gaps, some long enough to starve a frame.
      for (int i = 0; i < 12; i++) begin
         idle($urandom_range(0, 2*FRAME));
         l = NB'($urandom);
         r = NB'($urandom);
         send(l, r);
      end
      idle(2*FRAME);

      // Reset at f=5 of a frame while a second pair is held.
      send(8'h11, 8'h22);
      send(8'h33, 8'h44);
      idle(5*2*CD - 1);
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      idle(3*FRAME);

      check("frames_decoded_enough", frames_rx >= 20, 1'b1);
      check("frames_pending_at_end", q_exp.size() <= 1, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
